// File: rtl/axi_ic_pkg.sv
// Shared types and helpers for the AXI interconnect.
// Holds the AW arbiter state encoding and index wrap-around helper.
package axi_ic_pkg;

    typedef enum logic {
        AW_IDLE   = 1'b0,
        AW_LOCKED = 1'b1
    } aw_state_e;

    function automatic int wrap_idx(input int idx, input int n);
        return idx % n;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin winner search, purely combinational.
// Search starts one past the last grant and wraps modulo Masters_Num.
module rr_priority_picker
    import axi_ic_pkg::*;
#(
    parameter int Masters_Num = 2,
    parameter int ID_Size     = $clog2(Masters_Num)
) (
    input  logic [Masters_Num-1:0] i_req,
    input  logic [ID_Size-1:0]     i_last,
    output logic [ID_Size-1:0]     o_winner,
    output logic                   o_any
);

    logic               w_found;
    logic [ID_Size-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_any    = |i_req;
        w_found  = 1'b0;
        w_idx    = '0;
        // Last iteration lands back on i_last, so a lone repeat requester wins.
        for (int k = 1; k <= Masters_Num; k++) begin
            w_idx = ID_Size'(wrap_idx(int'(i_last) + k, Masters_Num));
            if (!w_found && i_req[w_idx]) begin
                o_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aw_rr_arbiter.sv
// Round-robin AW channel arbiter sharing one slave-side AW port.
// Locks a winner until its handshake; pauses arbitration while the route queue is full.
module aw_rr_arbiter
    import axi_ic_pkg::*;
#(
    parameter int Masters_Num = 2,
    parameter int ID_Size     = $clog2(Masters_Num),
    parameter int Addr_Width  = 32,
    parameter int Len_Width   = 8
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [Masters_Num-1:0]            M_AWVALID,
    input  logic [Masters_Num*Addr_Width-1:0] M_AWADDR,
    input  logic [Masters_Num*Len_Width-1:0]  M_AWLEN,
    output logic [Masters_Num-1:0]            M_AWREADY,
    output logic                              S_AWVALID,
    output logic [Addr_Width-1:0]             S_AWADDR,
    output logic [Len_Width-1:0]              S_AWLEN,
    input  logic                              S_AWREADY,
    input  logic                              Queue_Is_Full,
    output logic                              AW_Access_Grant,
    output logic [ID_Size-1:0]                Granted_ID,
    output logic                              Busy
);

    aw_state_e          r_state;
    aw_state_e          w_state_nxt;
    logic [ID_Size-1:0] r_gid;
    logic [ID_Size-1:0] r_last;
    logic [ID_Size-1:0] w_winner;
    logic               w_any;
    logic               w_start;
    logic               w_hs;

    rr_priority_picker #(
        .Masters_Num (Masters_Num),
        .ID_Size     (ID_Size)
    ) u_pick (
        .i_req    (M_AWVALID),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= AW_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reset points r_last at the top master so master 0 is searched first.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_gid  <= '0;
            r_last <= ID_Size'(Masters_Num - 1);
        end else begin
            if (w_start) begin
                r_gid <= w_winner;
            end
            if (w_hs) begin
                r_last <= r_gid;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_start         = 1'b0;
        w_hs            = 1'b0;
        S_AWVALID       = 1'b0;
        S_AWADDR        = '0;
        S_AWLEN         = '0;
        M_AWREADY       = '0;
        AW_Access_Grant = 1'b0;
        Busy            = 1'b0;
        unique case (r_state)
            AW_IDLE: begin
                if (!Queue_Is_Full && w_any) begin
                    w_start     = 1'b1;
                    w_state_nxt = AW_LOCKED;
                end
            end
            AW_LOCKED: begin
                S_AWVALID        = 1'b1;
                Busy             = 1'b1;
                S_AWADDR         = M_AWADDR[int'(r_gid)*Addr_Width +: Addr_Width];
                S_AWLEN          = M_AWLEN[int'(r_gid)*Len_Width +: Len_Width];
                M_AWREADY[r_gid] = S_AWREADY;
                if (S_AWREADY) begin
                    w_hs            = 1'b1;
                    AW_Access_Grant = 1'b1;
                    w_state_nxt     = AW_IDLE;
                end
            end
            default: ;
        endcase
    end

    assign Granted_ID = r_gid;

endmodule

// File: tb/tb_aw_rr_arbiter.sv
// Bench for aw_rr_arbiter: 2- and 3-master instances against a behavioural model.
// Directed scenarios first, then randomized traffic.
module tb_aw_rr_arbiter;

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;
    logic ARESETN;

    logic [1:0]  v2;
    logic [63:0] a2;
    logic [15:0] l2;
    logic [1:0]  r2;
    logic        sv2, sr2, qf2, g2, b2;
    logic [31:0] sa2;
    logic [7:0]  sl2;
    logic [0:0]  id2;

    logic [2:0]  v3;
    logic [95:0] a3;
    logic [23:0] l3;
    logic [2:0]  r3;
    logic        sv3, sr3, qf3, g3, b3;
    logic [31:0] sa3;
    logic [7:0]  sl3;
    logic [1:0]  id3;

    bit lk2, lk3;
    int gid2, gid3, last2, last3;
    int n_chk = 0;
    int n_pass = 0;

    aw_rr_arbiter #(.Masters_Num(2)) dut2 (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .M_AWVALID(v2), .M_AWADDR(a2), .M_AWLEN(l2), .M_AWREADY(r2),
        .S_AWVALID(sv2), .S_AWADDR(sa2), .S_AWLEN(sl2), .S_AWREADY(sr2),
        .Queue_Is_Full(qf2), .AW_Access_Grant(g2), .Granted_ID(id2), .Busy(b2)
    );

    aw_rr_arbiter #(.Masters_Num(3)) dut3 (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .M_AWVALID(v3), .M_AWADDR(a3), .M_AWLEN(l3), .M_AWREADY(r3),
        .S_AWVALID(sv3), .S_AWADDR(sa3), .S_AWLEN(sl3), .S_AWREADY(sr3),
        .Queue_Is_Full(qf3), .AW_Access_Grant(g3), .Granted_ID(id3), .Busy(b3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h exp %0h", tag, got, exp);
    endtask

    // Round-robin rule: first requester at last+1, last+2, ... modulo n.
    function automatic int pick(input int n, input int last, input int req);
        for (int k = 1; k <= n; k++) begin
            int idx;
            idx = (last + k) % n;
            if (req[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic step_model(input int n, input bit sr, input bit qf, input int req,
                              inout bit lk, inout int gid, inout int last);
        if (lk) begin
            if (sr) begin
                lk   = 1'b0;
                last = gid;
            end
        end else if (!qf && req != 0) begin
            gid = pick(n, last, req);
            lk  = 1'b1;
        end
    endtask

    task automatic reset_models();
        lk2 = 0; gid2 = 0; last2 = 1;
        lk3 = 0; gid3 = 0; last3 = 2;
    endtask

    task automatic check_outs(input string p, input bit lk, input int gid,
                              input logic [95:0] addr, input logic [23:0] len,
                              input bit sr, input logic sv, input logic [31:0] sa,
                              input logic [7:0] sl, input logic [2:0] mr,
                              input logic g, input logic [1:0] id, input logic b);
        logic [31:0] ea;
        logic [7:0]  el;
        logic [2:0]  er;
        ea = lk ? addr[gid*32 +: 32] : 32'h0;
        el = lk ? len[gid*8 +: 8] : 8'h0;
        er = (lk && sr) ? 3'(1 << gid) : 3'b0;
        chk({p, ".valid"}, 32'(sv), 32'(lk));
        chk({p, ".busy"}, 32'(b), 32'(lk));
        chk({p, ".id"}, 32'(id), 32'(gid));
        chk({p, ".addr"}, sa, ea);
        chk({p, ".len"}, 32'(sl), 32'(el));
        chk({p, ".mready"}, 32'(mr), 32'(er));
        chk({p, ".grant"}, 32'(g), 32'(lk && sr));
    endtask

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(negedge ACLK);
            check_outs("m2", lk2, gid2, {32'h0, a2}, {8'h0, l2}, sr2,
                       sv2, sa2, sl2, {1'b0, r2}, g2, {1'b0, id2}, b2);
            check_outs("m3", lk3, gid3, a3, l3, sr3,
                       sv3, sa3, sl3, r3, g3, id3, b3);
            @(posedge ACLK);
            if (!ARESETN) begin
                reset_models();
            end else begin
                step_model(2, sr2, qf2, int'(v2), lk2, gid2, last2);
                step_model(3, sr3, qf3, int'(v3), lk3, gid3, last3);
            end
            #1;
        end
    endtask

    task automatic rnd();
        v2  = 2'($urandom_range(0, 3));
        a2  = {$urandom, $urandom};
        l2  = 16'($urandom);
        sr2 = ($urandom_range(0, 3) != 0);
        qf2 = ($urandom_range(0, 4) == 0);
        v3  = 3'($urandom_range(0, 7));
        a3  = {$urandom, $urandom, $urandom};
        l3  = 24'($urandom);
        sr3 = ($urandom_range(0, 3) != 0);
        qf3 = ($urandom_range(0, 4) == 0);
    endtask

    initial begin
        ARESETN = 1'b0;
        v2 = '0; a2 = '0; l2 = '0; sr2 = 0; qf2 = 0;
        v3 = '0; a3 = '0; l3 = '0; sr3 = 0; qf3 = 0;
        reset_models();
        #2;
        cycle(2);
        ARESETN = 1'b1;

        // Both masters requesting, slave always ready: 0,1,0,1
        v2 = 2'b11; sr2 = 1; a2 = {32'hBBBB0001, 32'hAAAA0000}; l2 = 16'h0705;
        v3 = 3'b111; sr3 = 1; a3 = {32'h3, 32'h2, 32'h1}; l3 = 24'h030201;
        cycle();
        chk("t1.id0", 32'(id2), 32'd0);
        chk("t1.busy", 32'(b2), 32'd1);
        cycle(2);
        chk("t1.id1", 32'(id2), 32'd1);
        cycle(6);

        // Lone master 1 with slave stalled
        v2 = 2'b00; cycle(2);
        v2 = 2'b10; sr2 = 0; a2 = {32'h0000_1000, 32'hDEAD_0000}; l2 = 16'h0300;
        cycle(6);
        chk("t2.addr", sa2, 32'h1000);
        chk("t2.len", 32'(sl2), 32'd3);
        sr2 = 1; cycle();
        v2 = 2'b00; sr2 = 0; cycle(2);

        // Queue full blocks arbitration
        qf2 = 1; v2 = 2'b01; sr2 = 1; cycle(4);
        chk("t3.blocked", 32'(sv2), 32'd0);
        qf2 = 0; cycle();
        chk("t3.rise", 32'(sv2), 32'd1);
        v2 = 2'b00; cycle(2);

        // Queue fills while locked: transfer still completes
        v2 = 2'b01; sr2 = 0; cycle();
        qf2 = 1; cycle(2);
        sr2 = 1; cycle(4);
        qf2 = 0; v2 = 2'b00; cycle(2);

        // Async reset while locked, then wrap on the 3-master instance
        v2 = 2'b11; sr2 = 0; v3 = 3'b101; sr3 = 0; qf3 = 0;
        cycle(2);
        ARESETN = 1'b0;
        reset_models();
        #2;
        chk("t6.valid2", 32'(sv2), 32'd0);
        chk("t6.busy2", 32'(b2), 32'd0);
        chk("t6.valid3", 32'(sv3), 32'd0);
        cycle(2);
        ARESETN = 1'b1;
        cycle();
        chk("t6.first", 32'(id2), 32'd0);
        chk("t5.wrap", 32'(id3), 32'd0);
        sr2 = 1; sr3 = 1; cycle();
        sr2 = 0; sr3 = 0; cycle();
        chk("t5.next", 32'(id3), 32'd2);
        chk("t6.next", 32'(id2), 32'd1);
        cycle(2);

        repeat (600) begin
            rnd();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
